// File: rtl/button_press_classifier_pkg.sv
// Shared state encoding and counter width for the button press classifier.
package button_press_classifier_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRESS1 = 3'd1,
    S_WAIT2  = 3'd2,
    S_PRESS2 = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/button_press_classifier_edge_detect.sv
// Registers the button level and derives single-cycle rise/fall strobes.
module edge_detect (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Signal,
  output logic rise,
  output logic fall
);

  logic r_Prev;

  // Reset loads the live level so a button held across reset release gives no rise.
  always_ff @(posedge i_Clk) begin
    r_Prev <= i_Signal;
  end

  assign rise = i_Signal & ~r_Prev;
  assign fall = ~i_Signal & r_Prev;

  // i_Rst is accepted for interface symmetry; reset and run behave identically here.
  logic unused_rst;
  assign unused_rst = i_Rst;

endmodule

// File: rtl/button_press_classifier.sv
// Classifies button activity into short, double and long presses with an event counter.
// o_State exposes the FSM state for debug and checker binding.
module button_press_classifier
  import button_press_classifier_pkg::*;
#(
  parameter int unsigned LONG_TICKS   = 25000000,
  parameter int unsigned DOUBLE_TICKS = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Signal,
  output logic       o_ShortPress,
  output logic       o_DoublePress,
  output logic       o_LongPress,
  output logic       o_Held,
  output logic [7:0] o_EventCount,
  output logic [2:0] o_State
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);

  logic             rise;
  logic             fall;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  edge_detect u_edge (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .i_Signal (i_Signal),
    .rise     (rise),
    .fall     (fall)
  );

  // Edges are tested before thresholds so an edge wins a same-cycle tie.
  // cnt only runs in the timed states, which bounds it by the active threshold.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      o_ShortPress  <= 1'b0;
      o_DoublePress <= 1'b0;
      o_LongPress   <= 1'b0;
      o_Held        <= 1'b0;
      o_EventCount  <= 8'd0;
    end else begin
      o_ShortPress  <= 1'b0;
      o_DoublePress <= 1'b0;
      o_LongPress   <= 1'b0;
      cnt           <= cnt + 1'b1;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rise) state <= S_PRESS1;
        end
        S_PRESS1: begin
          if (fall) begin
            state <= S_WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            state        <= S_HOLD;
            cnt          <= '0;
            o_LongPress  <= 1'b1;
            o_Held       <= 1'b1;
            o_EventCount <= o_EventCount + 8'd1;
          end
        end
        S_WAIT2: begin
          if (rise) begin
            state <= S_PRESS2;
            cnt   <= '0;
          end else if (cnt == DOUBLE_LAST) begin
            state        <= S_IDLE;
            cnt          <= '0;
            o_ShortPress <= 1'b1;
            o_EventCount <= o_EventCount + 8'd1;
          end
        end
        S_PRESS2: begin
          if (fall) begin
            state         <= S_IDLE;
            cnt           <= '0;
            o_DoublePress <= 1'b1;
            o_EventCount  <= o_EventCount + 8'd1;
          end else if (cnt == LONG_LAST) begin
            state        <= S_HOLD;
            cnt          <= '0;
            o_LongPress  <= 1'b1;
            o_Held       <= 1'b1;
            o_EventCount <= o_EventCount + 8'd1;
          end
        end
        S_HOLD: begin
          cnt <= '0;
          if (fall) begin
            state  <= S_IDLE;
            o_Held <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          o_Held <= 1'b0;
        end
      endcase
    end
  end

  assign o_State = state;

endmodule

// File: doc/button_press_classifier.md
BUTTON_PRESS_CLASSIFIER -- requirements
Module: button_press_classifier

Interface
REQ-001 Parameter LONG_TICKS, default 25000000, minimum hold in cycles for a long press; legal range 2..2^32-1.
REQ-002 Parameter DOUBLE_TICKS, default 6250000, maximum release gap in cycles for a double press; legal range 2..2^32-1.
REQ-003 i_Clk  in  1  sole clock; all logic on its rising edge.
REQ-004 i_Rst  in  1  reset, synchronous, active-high.
REQ-005 i_Signal  in  1  debounced button level, 1 = pressed; already synchronous to i_Clk.
REQ-006 o_ShortPress  out  1  one-cycle pulse: single short press classified.
REQ-007 o_DoublePress  out  1  one-cycle pulse: double press classified.
REQ-008 o_LongPress  out  1  one-cycle pulse: long-press threshold reached.
REQ-009 o_Held  out  1  level, high while in HOLD.
REQ-010 o_EventCount  out  8  running count of all emitted pulses; wraps 255->0.

Function
REQ-011 r_Prev registers i_Signal each cycle; rise = i_Signal & ~r_Prev; fall = ~i_Signal & r_Prev.
REQ-012 States: IDLE, PRESS1, WAIT2, PRESS2, HOLD; 32-bit counter cnt is cleared on every state entry and increments by 1 every cycle otherwise.
REQ-013 IDLE: rise -> PRESS1; otherwise stay.
REQ-014 PRESS1: fall -> WAIT2; else if cnt == LONG_TICKS-1 -> HOLD with o_LongPress pulse.
REQ-015 WAIT2: rise -> PRESS2; else if cnt == DOUBLE_TICKS-1 -> IDLE with o_ShortPress pulse.
REQ-016 PRESS2: fall -> IDLE with o_DoublePress pulse; else if cnt == LONG_TICKS-1 -> HOLD with o_LongPress pulse; the first click is discarded.
REQ-017 HOLD: fall -> IDLE; no pulse; o_Held = 1 for every cycle in HOLD.
REQ-018 All outputs are registered; each pulse is high for exactly one cycle, on the cycle the FSM enters its target state.
REQ-019 Latency: o_LongPress is high exactly LONG_TICKS+1 cycles after the cycle in which rise is sampled.
REQ-020 Latency: o_ShortPress is high exactly DOUBLE_TICKS+1 cycles after the cycle in which the release fall is sampled.
REQ-021 When an edge and a counter threshold occur in the same cycle, the edge wins.
REQ-022 At most one of the three pulses is high in any cycle.
REQ-023 o_EventCount increments by 1 in the same cycle each pulse is high; modulo 256.
REQ-024 cnt never exceeds the active threshold; no counter overflow is possible.

Reset
REQ-025 While i_Rst = 1, on each clock: state = IDLE, cnt = 0, all pulses = 0, o_Held = 0, o_EventCount = 0.
REQ-026 While i_Rst = 1, r_Prev loads i_Signal, so a button held through reset release produces no rise.
REQ-027 Reset asserted mid-press or mid-gap aborts classification; no pulse is emitted for the aborted sequence.

Structure
REQ-028 A shared package holds the state encoding constants (3-bit) and the counter width constant (32).
REQ-029 A single sub-module, edge_detect, supplies r_Prev, rise and fall; it has the same i_Clk/i_Rst and honours REQ-026.

Verification (LONG_TICKS = 20, DOUBLE_TICKS = 10)
REQ-030 Press 5 cycles, release, idle 30 -> one o_ShortPress, 11 cycles after the fall is sampled; o_EventCount = 1.
REQ-031 Press 5, release 4, press 5, release -> one o_DoublePress on PRESS2 exit; no o_ShortPress; o_EventCount = 1.
REQ-032 Press 40 cycles -> o_LongPress 21 cycles after rise; o_Held high until the fall is sampled; no further pulse.
REQ-033 Edges at boundaries: rise in WAIT2 when cnt = 9 -> PRESS2 entered, no o_ShortPress; fall in PRESS1 when cnt = 19 -> WAIT2 entered, no o_LongPress.
REQ-034 Assert i_Rst for 3 cycles mid-press with i_Signal held high, then deassert -> no pulse and state stays IDLE until release and re-press.
REQ-035 256 short presses -> o_EventCount wraps to 0; 257th short press -> o_EventCount = 1.
